// File: rtl/compare_result_tally_pkg.sv
// Shared constants for the comparator result tally: F bit positions,
// legal one-hot codes and the tracking FSM state encoding.
package compare_result_tally_pkg;

  localparam int F_GT = 2;
  localparam int F_EQ = 1;
  localparam int F_LT = 0;

  localparam logic [2:0] CODE_GT = 3'(1 << F_GT);
  localparam logic [2:0] CODE_EQ = 3'(1 << F_EQ);
  localparam logic [2:0] CODE_LT = 3'(1 << F_LT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOCK = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == CODE_GT) || (code == CODE_EQ) || (code == CODE_LT);
  endfunction

endpackage

// File: rtl/compare_result_tally_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/compare_result_tally.sv
// Tallies comparator outcomes, tracks runs of identical outcomes and
// latches a sticky error on any non-one-hot result code.
module compare_result_tally
  import compare_result_tally_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             f_valid,
  input  logic [2:0]       f,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [2:0]       last_f,
  output logic [3:0]       streak,
  output logic             lock,
  output logic             err
);

  localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

  state_t state;
  logic   legal;
  logic   accept;

  assign legal  = is_legal(f);
  assign accept = f_valid && legal && !clear;

  sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (accept && (f == CODE_GT)),
    .count(gt_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (accept && (f == CODE_EQ)),
    .count(eq_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear),
    .inc  (accept && (f == CODE_LT)),
    .count(lt_cnt)
  );

  // Once in S_ERR the run tracking is frozen until rst/clear; counters keep going.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= S_IDLE;
      last_f <= 3'b000;
      streak <= 4'd0;
      err    <= 1'b0;
    end else if (f_valid) begin
      case (state)
        S_IDLE: begin
          if (legal) begin
            last_f <= f;
            streak <= 4'd1;
            state  <= S_RUN;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        end
        S_RUN: begin
          if (!legal) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else if (f == last_f) begin
            streak <= streak + 4'd1;
            if ((streak + 4'd1) == RUN_MAX) begin
              state <= S_LOCK;
            end
          end else begin
            last_f <= f;
            streak <= 4'd1;
          end
        end
        S_LOCK: begin
          if (!legal) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else if (f != last_f) begin
            last_f <= f;
            streak <= 4'd1;
            state  <= S_RUN;
          end
        end
        S_ERR: begin
          err <= 1'b1;
        end
      endcase
    end
  end

  assign lock = (state == S_LOCK);

endmodule

// File: tb/tb_compare_result_tally.sv
// Randomised bench for compare_result_tally against a history-based reference model.
module tb_compare_result_tally;

  localparam int RUN_LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       f_valid = 1'b0;
  logic [2:0] f = 3'b000;

  logic [7:0] gt_cnt, eq_cnt, lt_cnt;
  logic [2:0] last_f;
  logic [3:0] streak;
  logic       lock, err;

  logic [1:0] gt_cnt_s, eq_cnt_s, lt_cnt_s;
  logic [2:0] last_f_s;
  logic [3:0] streak_s;
  logic       lock_s, err_s;

  int assertions = 0;
  int failures   = 0;

  // Reference model: legal codes seen since the last reset (until an error), raw totals
  logic [2:0] hist[$];
  int         raw_gt, raw_eq, raw_lt;
  bit         m_err;
  logic [2:0] prev_legal = 3'b100;

  always #5 clk = ~clk;

  compare_result_tally #(.CNT_W(8), .RUN_LEN(RUN_LEN)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .f_valid(f_valid), .f(f),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .last_f(last_f), .streak(streak), .lock(lock), .err(err)
  );

  compare_result_tally #(.CNT_W(2), .RUN_LEN(RUN_LEN)) u_small (
    .clk(clk), .rst(rst), .clear(clear), .f_valid(f_valid), .f(f),
    .gt_cnt(gt_cnt_s), .eq_cnt(eq_cnt_s), .lt_cnt(lt_cnt_s),
    .last_f(last_f_s), .streak(streak_s), .lock(lock_s), .err(err_s)
  );

  task automatic check_output(input string tag, input int observed, input int expected);
    assertions++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int sat(input int raw, input int max);
    return (raw > max) ? max : raw;
  endfunction

  function automatic bit legal_code(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  function automatic int exp_streak();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0 && n < RUN_LEN; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_update();
    if (rst || clear) begin
      hist.delete();
      raw_gt = 0; raw_eq = 0; raw_lt = 0;
      m_err  = 1'b0;
    end else if (f_valid) begin
      if (legal_code(f)) begin
        if (f == 3'b100) raw_gt++;
        if (f == 3'b010) raw_eq++;
        if (f == 3'b001) raw_lt++;
        if (!m_err) hist.push_back(f);
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    int s;
    int lf;
    s  = exp_streak();
    lf = (hist.size() == 0) ? 0 : int'(hist[hist.size() - 1]);
    check_output("gt_cnt", int'(gt_cnt), sat(raw_gt, 255));
    check_output("eq_cnt", int'(eq_cnt), sat(raw_eq, 255));
    check_output("lt_cnt", int'(lt_cnt), sat(raw_lt, 255));
    check_output("last_f", int'(last_f), lf);
    check_output("streak", int'(streak), s);
    check_output("lock", int'(lock), int'(s == RUN_LEN && !m_err));
    check_output("err", int'(err), int'(m_err));
    check_output("gt_cnt_w2", int'(gt_cnt_s), sat(raw_gt, 3));
    check_output("eq_cnt_w2", int'(eq_cnt_s), sat(raw_eq, 3));
    check_output("lt_cnt_w2", int'(lt_cnt_s), sat(raw_lt, 3));
    check_output("err_w2", int'(err_s), int'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check just after it
  task automatic apply_stimulus(input logic r, input logic c, input logic v, input logic [2:0] code);
    rst = r; clear = c; f_valid = v; f = code;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    raw_gt = 0; raw_eq = 0; raw_lt = 0; m_err = 1'b0;

    repeat (2) apply_stimulus(1, 0, 0, 3'b000);
    repeat (5) apply_stimulus(0, 0, 0, 3'b000);

    repeat (5) apply_stimulus(0, 0, 1, 3'b100);
    apply_stimulus(0, 0, 1, 3'b001);
    apply_stimulus(0, 0, 1, 3'b010);

    apply_stimulus(0, 0, 1, 3'b011);
    repeat (3) apply_stimulus(0, 0, 1, 3'b010);
    apply_stimulus(0, 1, 0, 3'b000);

    repeat (6) apply_stimulus(0, 0, 1, 3'b010);

    apply_stimulus(0, 1, 1, 3'b100);
    repeat (3) apply_stimulus(0, 0, 1, 3'b001);
    apply_stimulus(1, 0, 1, 3'b001);
    apply_stimulus(0, 0, 0, 3'b001);

    for (int i = 0; i < 600; i++) begin
      logic       r, c, v;
      logic [2:0] code;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0) begin
        do code = 3'($urandom_range(0, 7)); while (legal_code(code));
      end else if ($urandom_range(0, 9) < 7) begin
        code = prev_legal;
      end else begin
        case ($urandom_range(0, 2))
          0:       code = 3'b100;
          1:       code = 3'b010;
          default: code = 3'b001;
        endcase
      end
      if (legal_code(code)) prev_legal = code;
      apply_stimulus(r, c, v, code);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
